// File: rtl/cpu_pkg.sv
// Shared RV32I pipeline definitions: opcodes, stage/hazard codes, NOP and the
// fetch-to-decode entry carried through the fetch buffer.
package cpu_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPCODE_R       = 7'b0110011;
   localparam logic [6:0] OPCODE_I_LOAD  = 7'b0000011;
   localparam logic [6:0] OPCODE_I_OTHER = 7'b0010011;
   localparam logic [6:0] OPCODE_JAL     = 7'b1101111;
   localparam logic [6:0] OPCODE_S       = 7'b0100011;
   localparam logic [6:0] OPCODE_B       = 7'b1100011;
   localparam logic [6:0] OPCODE_LUI     = 7'b0110111;
   localparam logic [6:0] OPCODE_JALR    = 7'b1100111;
   localparam logic [6:0] OPCODE_AUIPC   = 7'b0010111;

   typedef enum logic [1:0] {
      STAGE_DECODE,
      STAGE_EXECUTE,
      STAGE_MEMORY,
      STAGE_WRITEBACK
   } pipe_stage_e;

   typedef enum logic [2:0] {
      HZ_NONE,
      HZ_R,
      HZ_I_LOAD,
      HZ_I_OTHER,
      HZ_S,
      HZ_B,
      HZ_JUMP,
      HZ_UPPER
   } hazard_type_e;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instruction;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch -> decode valid/ready handshake. Fetch drives through master,
// decode through slave.
interface fetch_stage_if;
   import cpu_pkg::*;

   logic            DECODE_VALID;
   logic            DECODE_READY;
   logic [XLEN-1:0] DECODE_INSTRUCTION;
   logic [XLEN-1:0] DECODE_PC;

   modport master (
      output DECODE_VALID,
      output DECODE_INSTRUCTION,
      output DECODE_PC,
      input  DECODE_READY
   );

   modport slave (
      input  DECODE_VALID,
      input  DECODE_INSTRUCTION,
      input  DECODE_PC,
      output DECODE_READY
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small fetch buffer: power-of-2 depth, synchronous flush (wins over push/pop),
// push and pop allowed in the same cycle.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // entry storage; contents are don't-care while empty
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives the synchronous
// instruction memory, buffers returned words and hands {instruction, pc} to
// decode. EXECUTE redirects flush wrong-path work and toggle the fetch epoch.
// Optional build macro FETCH_PERF_COUNTERS_EN adds saturating stall/flush
// counters.
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          ADDR_WIDTH = 10,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [31:0]           INSTRUCTION,
   output logic [ADDR_WIDTH-1:0] INSTRUCTION_ADDR,
   input  logic                  REDIRECT_VALID,
   input  logic [31:0]           REDIRECT_PC,
   fetch_stage_if.master         dec
`ifdef FETCH_PERF_COUNTERS_EN
   ,
   output logic [31:0]           FETCH_STALL_COUNT,
   output logic [31:0]           FETCH_FLUSH_COUNT
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]    pc;
   logic           in_flight;
   logic [31:0]    inflight_pc;
   logic           inflight_epoch;
   logic           epoch;
   logic           issue;
   logic           fifo_push;
   logic           fifo_pop;
   logic [CW-1:0]  fifo_count;
   logic           fifo_full;
   logic           fifo_empty;
   fetch_entry_t   fifo_head;
   fetch_entry_t   fifo_wdata;
   logic           unused_bits;

   // A pop in this cycle frees a slot for the word that returns next cycle,
   // which is what lets a ready decode stage take one instruction per cycle.
   assign issue = !REDIRECT_VALID &&
                  ((int'(fifo_count) + int'(in_flight) - int'(fifo_pop)) < FIFO_DEPTH);

   // Stale responses can only come from an older epoch; they are dropped.
   assign fifo_push  = in_flight && (inflight_epoch == epoch);
   assign fifo_pop   = dec.DECODE_VALID && dec.DECODE_READY;
   assign fifo_wdata = '{instruction: INSTRUCTION, pc: inflight_pc};

   // Redirect target low bits are ignored; fifo_full is informational here.
   assign unused_bits = ^{REDIRECT_PC[1:0], fifo_full};

   // PC, memory address and in-flight tracking
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc               <= RESET_PC;
         INSTRUCTION_ADDR <= RESET_PC[ADDR_WIDTH+1:2];
         in_flight        <= 1'b0;
         inflight_pc      <= '0;
         inflight_epoch   <= 1'b0;
         epoch            <= 1'b0;
      end else if (REDIRECT_VALID) begin
         pc               <= {REDIRECT_PC[31:2], 2'b00};
         INSTRUCTION_ADDR <= REDIRECT_PC[ADDR_WIDTH+1:2];
         in_flight        <= 1'b0;
         epoch            <= ~epoch;
      end else begin
         in_flight <= issue;
         if (issue) begin
            inflight_pc      <= pc;
            inflight_epoch   <= epoch;
            pc               <= pc + 32'd4;
            INSTRUCTION_ADDR <= INSTRUCTION_ADDR + 1'b1;
         end
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (CLK),
      .rst   (RESET),
      .flush (REDIRECT_VALID),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .head  (fifo_head),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Present NOP / pc 0 whenever nothing valid is at the head.
   assign dec.DECODE_VALID       = !fifo_empty;
   assign dec.DECODE_INSTRUCTION = fifo_empty ? NOP   : fifo_head.instruction;
   assign dec.DECODE_PC          = fifo_empty ? 32'd0 : fifo_head.pc;

`ifdef FETCH_PERF_COUNTERS_EN
   // saturating counts of decode back-pressure cycles and redirect cycles
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         FETCH_STALL_COUNT <= '0;
         FETCH_FLUSH_COUNT <= '0;
      end else begin
         if (dec.DECODE_VALID && !dec.DECODE_READY && (FETCH_STALL_COUNT != '1))
            FETCH_STALL_COUNT <= FETCH_STALL_COUNT + 32'd1;
         if (REDIRECT_VALID && (FETCH_FLUSH_COUNT != '1))
            FETCH_FLUSH_COUNT <= FETCH_FLUSH_COUNT + 32'd1;
      end
   end
`endif

endmodule
